rx_stream_arbiter: RTL and testbench

//  Merges the decimated I/Q streams of NUM_RX receiver chains into one output stream

---
 rtl/rx_stream_arbiter.sv | 127 ++++++++++++
 tb/tb_rx_stream_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_stream_arbiter.sv
// Merges the sample streams of NUM_RX receiver chains into one valid/ready output stream.
// Each chain has a one-deep holding register, and the chains are granted in round-robin order.
module rx_stream_arbiter #(
   parameter int NUM_RX = 2,
   parameter int DATA_W = 24,
   parameter int CH_W   = 3
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [NUM_RX-1:0]        rx_strobe,
   input  logic [NUM_RX*DATA_W-1:0] rx_data_I,
   input  logic [NUM_RX*DATA_W-1:0] rx_data_Q,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CH_W-1:0]          out_channel,
   output logic [7:0]               out_seq,
   output logic [DATA_W-1:0]        out_I,
   output logic [DATA_W-1:0]        out_Q,
   output logic [NUM_RX-1:0]        overrun,
   input  logic                     clear_overrun
);

   typedef enum logic {S_EMPTY, S_FULL} out_state_t;

   out_state_t        state;
   logic [NUM_RX-1:0] pending;
   logic [DATA_W-1:0] hold_I   [NUM_RX];
   logic [DATA_W-1:0] hold_Q   [NUM_RX];
   logic [7:0]        hold_seq [NUM_RX];
   logic [7:0]        seq_cnt  [NUM_RX];
   logic [CH_W-1:0]   rr_ptr;

   logic              do_grant;
   logic              gnt_found;
   logic [CH_W-1:0]   gnt_idx;
   logic [DATA_W-1:0] sel_I;
   logic [DATA_W-1:0] sel_Q;
   logic [7:0]        sel_seq;

   // Round-robin search: first look at channels at or above rr_ptr, then wrap to the bottom.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int j = 0; j < NUM_RX; j++) begin
         if (!gnt_found && pending[j] && (CH_W'(j) >= rr_ptr)) begin
            gnt_found = 1'b1;
            gnt_idx   = CH_W'(j);
         end
      end
      for (int j = 0; j < NUM_RX; j++) begin
         if (!gnt_found && pending[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = CH_W'(j);
         end
      end
   end

   always_comb begin
      sel_I   = '0;
      sel_Q   = '0;
      sel_seq = '0;
      for (int j = 0; j < NUM_RX; j++) begin
         if (CH_W'(j) == gnt_idx) begin
            sel_I   = hold_I[j];
            sel_Q   = hold_Q[j];
            sel_seq = hold_seq[j];
         end
      end
   end

   assign do_grant = gnt_found && ((state == S_EMPTY) || out_ready);

   // Output register FSM. A grant while FULL and ready gives back-to-back beats.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_EMPTY;
         out_valid   <= 1'b0;
         out_channel <= '0;
         out_seq     <= '0;
         out_I       <= '0;
         out_Q       <= '0;
         rr_ptr      <= '0;
      end else begin
         if (do_grant) begin
            state       <= S_FULL;
            out_valid   <= 1'b1;
            out_channel <= gnt_idx;
            out_seq     <= sel_seq;
            out_I       <= sel_I;
            out_Q       <= sel_Q;
            rr_ptr      <= (gnt_idx == CH_W'(NUM_RX - 1)) ? '0 : gnt_idx + 1'b1;
         end else if ((state == S_FULL) && out_ready) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
         end
      end
   end

   // Per-chain capture. A strobe on a granted channel is a collision, not an overrun.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
         overrun <= '0;
         for (int k = 0; k < NUM_RX; k++) begin
            hold_I[k]   <= '0;
            hold_Q[k]   <= '0;
            hold_seq[k] <= '0;
            seq_cnt[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_RX; k++) begin
            if (rx_strobe[k]) begin
               hold_I[k]   <= rx_data_I[k*DATA_W +: DATA_W];
               hold_Q[k]   <= rx_data_Q[k*DATA_W +: DATA_W];
               hold_seq[k] <= seq_cnt[k];
               seq_cnt[k]  <= seq_cnt[k] + 8'd1;
               pending[k]  <= 1'b1;
            end else if (do_grant && (gnt_idx == CH_W'(k))) begin
               pending[k] <= 1'b0;
            end
            overrun[k] <= (rx_strobe[k] && pending[k] && !(do_grant && (gnt_idx == CH_W'(k))))
                          || (overrun[k] && !clear_overrun);
         end
      end
   end

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Self-checking bench for rx_stream_arbiter: a table of per-cycle vectors plus directed
// sequences for reset/idle, round robin, sequence wrap and asynchronous reset mid-stream.
module tb_rx_stream_arbiter;

   localparam int NUM_RX = 2;
   localparam int DATA_W = 24;
   localparam int CH_W   = 3;

   logic                     clock = 1'b0;
   logic                     reset_n = 1'b0;
   logic [NUM_RX-1:0]        rx_strobe = '0;
   logic [NUM_RX*DATA_W-1:0] rx_data_I = '0;
   logic [NUM_RX*DATA_W-1:0] rx_data_Q = '0;
   logic                     out_valid;
   logic                     out_ready = 1'b0;
   logic [CH_W-1:0]          out_channel;
   logic [7:0]               out_seq;
   logic [DATA_W-1:0]        out_I;
   logic [DATA_W-1:0]        out_Q;
   logic [NUM_RX-1:0]        overrun;
   logic                     clear_overrun = 1'b0;

   int checks = 0;
   int errors = 0;

   rx_stream_arbiter #(.NUM_RX(NUM_RX), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
      .clock(clock), .reset_n(reset_n), .rx_strobe(rx_strobe),
      .rx_data_I(rx_data_I), .rx_data_Q(rx_data_Q),
      .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
      .out_seq(out_seq), .out_I(out_I), .out_Q(out_Q),
      .overrun(overrun), .clear_overrun(clear_overrun)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        rst_before;
      logic [1:0]  strobe;
      logic [23:0] i0, q0, i1, q1;
      logic        ready, clear;
      logic        exp_valid;
      logic [2:0]  exp_ch;
      logic [7:0]  exp_seq;
      logic [23:0] exp_i, exp_q;
      logic [1:0]  exp_ov;
      string       name;
   } vec_t;

   vec_t vecs[$];

   // Each vector's inputs are sampled by one rising edge; the expectation is the state after it.
   task automatic addVec(input string name, input logic rst, input logic [1:0] stb,
                         input logic [23:0] i0, input logic [23:0] q0,
                         input logic [23:0] i1, input logic [23:0] q1,
                         input logic rdy, input logic clr, input logic ev,
                         input logic [2:0] ech, input logic [7:0] eseq,
                         input logic [23:0] ei, input logic [23:0] eq, input logic [1:0] eov);
      vec_t v;
      v.name = name; v.rst_before = rst; v.strobe = stb;
      v.i0 = i0; v.q0 = q0; v.i1 = i1; v.q1 = q1;
      v.ready = rdy; v.clear = clr; v.exp_valid = ev; v.exp_ch = ech;
      v.exp_seq = eseq; v.exp_i = ei; v.exp_q = eq; v.exp_ov = eov;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] stb, input logic [23:0] i0, input logic [23:0] q0,
                                input logic [23:0] i1, input logic [23:0] q1,
                                input logic rdy, input logic clr);
      @(negedge clock);
      rx_strobe     = stb;
      rx_data_I     = {i1, i0};
      rx_data_Q     = {q1, q0};
      out_ready     = rdy;
      clear_overrun = clr;
   endtask

   task automatic stepEdge();
      @(posedge clock);
      #1;
   endtask

   task automatic resetDut();
      @(negedge clock);
      reset_n = 1'b0;
      rx_strobe = '0; out_ready = 1'b0; clear_overrun = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic checkAllZero(input string name);
      checkOutput(name, {out_valid, out_channel, out_seq, out_I, out_Q, overrun}, 64'd0);
   endtask

   initial begin
      // T2 single sample on ch1
      addVec("t2_strobe", 1, 2'b10, 0, 0, 24'h123456, 24'hABCDEF, 1, 0, 0, 0, 0, 0, 0, 2'b00);
      addVec("t2_beat",   0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 1, 0, 24'h123456, 24'hABCDEF, 2'b00);
      addVec("t2_after",  0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
      addVec("t2_idle",   0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
      // T4 backpressure and overrun on ch0
      addVec("t4_s1",     1, 2'b01, 1, 24'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      addVec("t4_g1",     0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 24'h11, 2'b00);
      addVec("t4_s2",     0, 2'b01, 2, 24'h22, 0, 0, 0, 0, 1, 0, 0, 1, 24'h11, 2'b00);
      addVec("t4_s3",     0, 2'b01, 3, 24'h33, 0, 0, 0, 0, 1, 0, 0, 1, 24'h11, 2'b01);
      addVec("t4_stall",  0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 24'h11, 2'b01);
      addVec("t4_beat2",  0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2, 3, 24'h33, 2'b01);
      addVec("t4_empty",  0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01);
      addVec("t4_clear",  0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00);
      // T5 collision, then clear coinciding with a new overrun
      addVec("t5_s1",     1, 2'b01, 24'hA1, 24'h1A, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
      addVec("t5_coll",   0, 2'b01, 24'hA2, 24'h2A, 0, 0, 1, 0, 1, 0, 0, 24'hA1, 24'h1A, 2'b00);
      addVec("t5_b2b",    0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 1, 24'hA2, 24'h2A, 2'b00);
      addVec("t5_empty",  0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
      addVec("t5_b1",     0, 2'b01, 24'hB1, 24'h1B, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      addVec("t5_gb1",    0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2, 24'hB1, 24'h1B, 2'b00);
      addVec("t5_b2",     0, 2'b01, 24'hB2, 24'h2B, 0, 0, 0, 0, 1, 0, 2, 24'hB1, 24'h1B, 2'b00);
      addVec("t5_setwin", 0, 2'b01, 24'hB3, 24'h3B, 0, 0, 0, 1, 1, 0, 2, 24'hB1, 24'h1B, 2'b01);
      addVec("t5_clr",    0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2, 24'hB1, 24'h1B, 2'b00);
      addVec("t5_b3",     0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 4, 24'hB3, 24'h3B, 2'b00);
      addVec("t5_done",   0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00);

      // T1 reset and idle
      reset_n = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      checkAllZero("t1_in_reset");
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         stepEdge();
         checkAllZero("t1_idle");
      end

      // Table-driven vectors
      foreach (vecs[n]) begin
         if (vecs[n].rst_before) resetDut();
         applyStimulus(vecs[n].strobe, vecs[n].i0, vecs[n].q0, vecs[n].i1, vecs[n].q1,
                       vecs[n].ready, vecs[n].clear);
         stepEdge();
         checkOutput({vecs[n].name, "_valid"}, 64'(out_valid), 64'(vecs[n].exp_valid));
         checkOutput({vecs[n].name, "_ovr"}, 64'(overrun), 64'(vecs[n].exp_ov));
         if (vecs[n].exp_valid) begin
            checkOutput({vecs[n].name, "_ch"}, 64'(out_channel), 64'(vecs[n].exp_ch));
            checkOutput({vecs[n].name, "_seq"}, 64'(out_seq), 64'(vecs[n].exp_seq));
            checkOutput({vecs[n].name, "_I"}, 64'(out_I), 64'(vecs[n].exp_i));
            checkOutput({vecs[n].name, "_Q"}, 64'(out_Q), 64'(vecs[n].exp_q));
         end
      end

      // T3 round robin: both chains strobed together, four rounds 200 cycles apart
      resetDut();
      for (int r = 0; r < 4; r++) begin
         applyStimulus(2'b11, 24'h100 + 24'(r), 24'h400 + 24'(r), 24'h200 + 24'(r),
                       24'h800 + 24'(r), 1, 0);
         stepEdge();
         checkOutput("t3_latency", 64'(out_valid), 64'd0);
         applyStimulus(2'b00, 0, 0, 0, 0, 1, 0);
         stepEdge();
         checkOutput("t3_first", {out_valid, 4'(out_channel), out_seq, out_I},
                     {1'b1, 4'd0, 8'(r), 24'h100 + 24'(r)});
         stepEdge();
         checkOutput("t3_second", {out_valid, 4'(out_channel), out_seq, out_Q},
                     {1'b1, 4'd1, 8'(r), 24'h800 + 24'(r)});
         stepEdge();
         checkOutput("t3_drain", 64'(out_valid), 64'd0);
         repeat (200) @(posedge clock);
      end

      // T6 sequence wrap across 300 ch0 samples
      resetDut();
      for (int s = 0; s < 300; s++) begin
         applyStimulus(2'b01, 24'(s), 24'(s) ^ 24'hFFFFFF, 0, 0, 1, 0);
         stepEdge();
         applyStimulus(2'b00, 0, 0, 0, 0, 1, 0);
         stepEdge();
         checkOutput("t6_beat", {out_valid, out_seq, out_I}, {1'b1, 8'(s % 256), 24'(s)});
         if (s == 256) checkOutput("t6_wrap", 64'(out_seq), 64'd0);
         stepEdge();
      end
      checkOutput("t6_no_ovr", 64'(overrun), 64'd0);

      // T6 asynchronous reset while a beat is stalled
      applyStimulus(2'b01, 24'h5A5A5A, 24'hA5A5A5, 0, 0, 0, 0);
      stepEdge();
      applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
      stepEdge();
      checkOutput("t6_stalled", 64'(out_valid), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      checkAllZero("t6_async_rst");
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      applyStimulus(2'b01, 24'h0C0FFE, 24'h00BEEF, 0, 0, 1, 0);
      stepEdge();
      applyStimulus(2'b00, 0, 0, 0, 0, 1, 0);
      stepEdge();
      checkOutput("t6_seq_restart", {out_valid, out_seq, out_I}, {1'b1, 8'd0, 24'h0C0FFE});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
